// File: rtl/fp_add_sched.sv
// fp_add_sched: two-requester round-robin scheduler in front of one shared
// combinational single-precision adder. One operation is in flight at a time:
// accept -> wait ADD_LAT cycles for the adder to settle -> hold the response
// until the consumer takes it.
module fp_add_sched #(
   parameter int ADD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // The counter is loaded with ADD_LAT-1 so that WAIT spans exactly ADD_LAT cycles.
   localparam logic [3:0] LAT_M1 = 4'(ADD_LAT - 1);

   state_t      state_reg;
   logic [31:0] op_a_reg;
   logic [31:0] op_b_reg;
   logic [31:0] rsp_data_reg;
   logic        rsp_valid_reg;
   logic        rsp_id_reg;
   logic        last_grant_reg;
   logic [3:0]  count_reg;

   logic [1:0]  valid_vec;
   logic [1:0]  ready_vec;
   logic        grant;
   logic        accept;
   logic [31:0] sel_a;
   logic [31:0] sel_b;

   assign valid_vec = {req1_valid, req0_valid};

   // Arbitration: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant = 1'b0;
      if (valid_vec == 2'b10) begin
         grant = 1'b1;
      end else if (valid_vec == 2'b11) begin
         grant = ~last_grant_reg;
      end
   end

   // Ready is offered only in IDLE, only to the granted requester, never during reset.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         assign ready_vec[gi] = rst_n && (state_reg == IDLE) && valid_vec[gi]
                                && (grant == (gi == 1));
      end
   endgenerate

   assign req0_ready = ready_vec[0];
   assign req1_ready = ready_vec[1];
   assign accept     = |ready_vec;

   // Operands from the winning requester; only used on the handshake cycle.
   assign sel_a = grant ? req1_a : req0_a;
   assign sel_b = grant ? req1_b : req0_b;

   // Adder inputs come straight from the latched operands so they stay stable
   // for the whole WAIT/RESP window.
   assign add_a     = op_a_reg;
   assign add_b     = op_b_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_id    = rsp_id_reg;
   assign busy      = (state_reg != IDLE);

   // Scheduler FSM: accept, count down the adder settle time, hold the response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
         rsp_data_reg   <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= 1'b0;
         last_grant_reg <= 1'b1;
         count_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_a_reg       <= sel_a;
                  op_b_reg       <= sel_b;
                  rsp_id_reg     <= grant;
                  last_grant_reg <= grant;
                  count_reg      <= LAT_M1;
                  state_reg      <= WAIT;
               end
            end
            WAIT: begin
               if (count_reg == 4'd0) begin
                  rsp_data_reg  <= add_out;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: three instances (ADD_LAT = 2, 4, 1) each driving a
// model adder that returns garbage until its inputs have been stable for ADD_LAT cycles.
`timescale 1ns/1ps
module tb_fp_add_sched;

   localparam int N = 3;
   localparam int LATS [N] = '{2, 4, 1};
   localparam logic [31:0] BAD = 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
      int          req;
   } vec_t;

   vec_t vt [7];

   logic        clk = 1'b0;
   logic        rst_n     [N];
   logic        v         [N][2];
   logic        rdy       [N][2];
   logic [31:0] opa       [N][2];
   logic [31:0] opb       [N][2];
   logic [31:0] add_a     [N];
   logic [31:0] add_b     [N];
   logic [31:0] add_out   [N];
   logic        rsp_valid [N];
   logic        rsp_ready [N];
   logic [31:0] rsp_data  [N];
   logic        rsp_id    [N];
   logic        busy      [N];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Shared adder model: the table's hand-computed IEEE-754 sums, NaN otherwise.
   function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 7; i++) begin
         if (vt[i].a == a && vt[i].b == b) return vt[i].sum;
      end
      return 32'h7FC0_0001;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_dut
         logic [31:0] last_a = '0;
         logic [31:0] last_b = '0;
         logic [31:0] out_q  = BAD;
         int          age    = 0;

         // Settle model: result only becomes valid after ADD_LAT stable cycles.
         always @(negedge clk) begin
            if (add_a[gi] !== last_a || add_b[gi] !== last_b) begin
               age   <= 1;
               out_q <= (LATS[gi] <= 1) ? model_sum(add_a[gi], add_b[gi]) : BAD;
            end else begin
               age   <= age + 1;
               out_q <= (age + 1 >= LATS[gi]) ? model_sum(add_a[gi], add_b[gi]) : BAD;
            end
            last_a <= add_a[gi];
            last_b <= add_b[gi];
         end
         assign add_out[gi] = out_q;

         fp_add_sched #(.ADD_LAT(LATS[gi])) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[gi]),
            .req0_valid (v[gi][0]),
            .req1_valid (v[gi][1]),
            .req0_ready (rdy[gi][0]),
            .req1_ready (rdy[gi][1]),
            .req0_a     (opa[gi][0]),
            .req0_b     (opb[gi][0]),
            .req1_a     (opa[gi][1]),
            .req1_b     (opb[gi][1]),
            .add_a      (add_a[gi]),
            .add_b      (add_b[gi]),
            .add_out    (add_out[gi]),
            .rsp_valid  (rsp_valid[gi]),
            .rsp_ready  (rsp_ready[gi]),
            .rsp_data   (rsp_data[gi]),
            .rsp_id     (rsp_id[gi]),
            .busy       (busy[gi])
         );
      end
   endgenerate

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Wait for rsp_valid after an acceptance edge; returns edges elapsed since acceptance.
   task automatic wait_rsp(input int k, output int edges);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid[k] && n < 30);
      if (!rsp_valid[k]) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_timeout inst%0d: got no rsp_valid expected rsp_valid within 30 cycles", k);
      end
      edges = n - 1;
   endtask

   // Full single operation on instance k from requester r using vector vi; starts at a negedge in IDLE.
   task automatic do_op(input int k, input int r, input int vi);
      int edges;
      v[k][r] = 1'b1;
      opa[k][r] = vt[vi].a;
      opb[k][r] = vt[vi].b;
      #1;
      chk($sformatf("ready_granted i%0d v%0d", k, vi), rdy[k][r], 1);
      chk($sformatf("ready_other i%0d v%0d", k, vi), rdy[k][1-r], 0);
      @(posedge clk);
      #1;
      v[k][r] = 1'b0;
      opa[k][r] = 32'h1234_5678;
      opb[k][r] = 32'h8765_4321;
      chk($sformatf("busy_after_accept i%0d v%0d", k, vi), busy[k], 1);
      chk($sformatf("add_a i%0d v%0d", k, vi), add_a[k], vt[vi].a);
      chk($sformatf("add_b i%0d v%0d", k, vi), add_b[k], vt[vi].b);
      wait_rsp(k, edges);
      chk($sformatf("latency i%0d v%0d", k, vi), edges, LATS[k]);
      chk($sformatf("rsp_data i%0d v%0d", k, vi), rsp_data[k], vt[vi].sum);
      chk($sformatf("rsp_id i%0d v%0d", k, vi), rsp_id[k], r);
      $display("op inst%0d req%0d a=%h b=%h -> data=%h id=%0d latency=%0d",
               k, r, vt[vi].a, vt[vi].b, rsp_data[k], rsp_id[k], edges);
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
      chk($sformatf("rsp_valid_drop i%0d v%0d", k, vi), rsp_valid[k], 0);
      chk($sformatf("busy_idle i%0d v%0d", k, vi), busy[k], 0);
   endtask

   task automatic reset_inst(input int k);
      rst_n[k] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[k] = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges;
      int g;
      int seen;

      vt[0] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0};  // 1 + 2 = 3
      vt[1] = '{32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 1};  // 3 + 4 = 7
      vt[2] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 0};  // 0.5 + 0.5 = 1
      vt[3] = '{32'h4120_0000, 32'hC0A0_0000, 32'h40A0_0000, 1};  // 10 + -5 = 5
      vt[4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 0};  // +0 + -0 = +0
      vt[5] = '{32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1};  // inf + 1 = inf
      vt[6] = '{32'h42C8_0000, 32'h42C8_0000, 32'h4348_0000, 0};  // 100 + 100 = 200

      for (int k = 0; k < N; k++) begin
         rst_n[k] = 1'b0;
         rsp_ready[k] = 1'b0;
         for (int r = 0; r < 2; r++) begin
            v[k][r] = 1'b1;          // valid during reset must not raise ready
            opa[k][r] = 32'hFFFF_FFFF;
            opb[k][r] = 32'hFFFF_FFFF;
         end
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("reset_ready0 i%0d", k), rdy[k][0], 0);
         chk($sformatf("reset_ready1 i%0d", k), rdy[k][1], 0);
         chk($sformatf("reset_busy i%0d", k), busy[k], 0);
         chk($sformatf("reset_rsp_valid i%0d", k), rsp_valid[k], 0);
         chk($sformatf("reset_rsp_data i%0d", k), rsp_data[k], 0);
         chk($sformatf("reset_rsp_id i%0d", k), rsp_id[k], 0);
         chk($sformatf("reset_add_a i%0d", k), add_a[k], 0);
         chk($sformatf("reset_add_b i%0d", k), add_b[k], 0);
         v[k][0] = 1'b0;
         v[k][1] = 1'b0;
         rst_n[k] = 1'b1;
      end
      @(negedge clk);

      // Table-driven single operations, ADD_LAT = 2
      for (int i = 0; i < 7; i++) begin
         do_op(0, vt[i].req, i);
         @(negedge clk);
      end

      // Tie after reset and sustained contention: grants 0,1,0,1,0,1
      reset_inst(0);
      v[0][0] = 1'b1; opa[0][0] = vt[0].a; opb[0][0] = vt[0].b;
      v[0][1] = 1'b1; opa[0][1] = vt[1].a; opb[0][1] = vt[1].b;
      for (int i = 0; i < 6; i++) begin
         g = i % 2;
         #1;
         chk($sformatf("contend_ready_win op%0d", i), rdy[0][g], 1);
         chk($sformatf("contend_ready_lose op%0d", i), rdy[0][1-g], 0);
         @(posedge clk);
         wait_rsp(0, edges);
         chk($sformatf("contend_latency op%0d", i), edges, LATS[0]);
         chk($sformatf("contend_id op%0d", i), rsp_id[0], g);
         chk($sformatf("contend_data op%0d", i), rsp_data[0], vt[g].sum);
         $display("contention op%0d -> id=%0d data=%h", i, rsp_id[0], rsp_data[0]);
         rsp_ready[0] = 1'b1;
         @(negedge clk);
         rsp_ready[0] = 1'b0;
      end
      v[0][0] = 1'b0;
      v[0][1] = 1'b0;
      @(negedge clk);

      // Backpressure: hold rsp_ready low 5 cycles in RESP
      v[0][0] = 1'b1; opa[0][0] = vt[2].a; opb[0][0] = vt[2].b;
      @(posedge clk);
      #1;
      v[0][1] = 1'b1; opa[0][1] = vt[3].a; opb[0][1] = vt[3].b;
      wait_rsp(0, edges);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("bp_rsp_valid c%0d", c), rsp_valid[0], 1);
         chk($sformatf("bp_rsp_data c%0d", c), rsp_data[0], vt[2].sum);
         chk($sformatf("bp_rsp_id c%0d", c), rsp_id[0], 0);
         chk($sformatf("bp_add_a c%0d", c), add_a[0], vt[2].a);
         chk($sformatf("bp_add_b c%0d", c), add_b[0], vt[2].b);
         chk($sformatf("bp_ready0 c%0d", c), rdy[0][0], 0);
         chk($sformatf("bp_ready1 c%0d", c), rdy[0][1], 0);
         chk($sformatf("bp_busy c%0d", c), busy[0], 1);
         @(negedge clk);
      end
      $display("backpressure inst0 held data=%h id=%0d for 5 cycles", rsp_data[0], rsp_id[0]);
      // Requests withdrawn before any grant; rsp_ready outside RESP must do nothing
      v[0][0] = 1'b0;
      v[0][1] = 1'b0;
      rsp_ready[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("idle_rsp_valid c%0d", c), rsp_valid[0], 0);
         chk($sformatf("idle_busy c%0d", c), busy[0], 0);
      end
      rsp_ready[0] = 1'b0;

      // ADD_LAT = 4: normal operation, then reset in WAIT cycle 2
      do_op(1, 1, 3);
      @(negedge clk);
      v[1][0] = 1'b1; opa[1][0] = vt[5].a; opb[1][0] = vt[5].b;
      @(posedge clk);
      #1;
      v[1][0] = 1'b0;
      @(negedge clk);             // WAIT cycle 1
      @(negedge clk);             // WAIT cycle 2
      rst_n[1] = 1'b0;
      v[1][0] = 1'b1;
      @(negedge clk);
      #1;
      chk("midwait_ready0", rdy[1][0], 0);
      chk("midwait_busy", busy[1], 0);
      chk("midwait_rsp_valid", rsp_valid[1], 0);
      chk("midwait_rsp_data", rsp_data[1], 0);
      chk("midwait_rsp_id", rsp_id[1], 0);
      chk("midwait_add_a", add_a[1], 0);
      chk("midwait_add_b", add_b[1], 0);
      v[1][0] = 1'b0;
      rst_n[1] = 1'b1;
      rsp_ready[1] = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[1] || busy[1]) seen++;
      end
      chk("midwait_no_stale_rsp", seen, 0);
      rsp_ready[1] = 1'b0;
      $display("reset mid-WAIT inst1 -> in-flight op discarded");

      // ADD_LAT = 1: back-to-back req1 with rsp_ready tied high
      rsp_ready[2] = 1'b1;
      v[2][1] = 1'b1; opa[2][1] = vt[6].a; opb[2][1] = vt[6].b;
      seen = 0;
      #1;
      while (!rdy[2][1] && seen < 10) begin
         @(negedge clk);
         #1;
         seen++;
      end
      chk("b2b_first_ready", rdy[2][1], 1);
      for (int c = 0; c < 9; c++) begin
         chk($sformatf("b2b_ready c%0d", c), rdy[2][1], (c % 3) == 0);
         chk($sformatf("b2b_rsp_valid c%0d", c), rsp_valid[2], (c % 3) == 2);
         if ((c % 3) == 2) begin
            chk($sformatf("b2b_rsp_data c%0d", c), rsp_data[2], vt[6].sum);
            chk($sformatf("b2b_rsp_id c%0d", c), rsp_id[2], 1);
            $display("b2b inst2 op%0d -> data=%h id=%0d", c / 3, rsp_data[2], rsp_id[2]);
         end
         @(negedge clk);
         #1;
      end
      v[2][1] = 1'b0;
      rsp_ready[2] = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
